// File: rtl/boot_pkg.sv
// Shared types and defaults for the UART boot loader and its receiver.
package boot_pkg;

  localparam logic [7:0] DEFAULT_MAGIC        = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    WAIT_MAGIC = 3'd0,
    LEN_LO     = 3'd1,
    LEN_HI     = 3'd2,
    DATA       = 3'd3,
    CSUM       = 3'd4,
    DONE       = 3'd5,
    ERR        = 3'd6
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // A frame may fill the RAM exactly, but never exceed it.
  function automatic logic len_oversize(input logic [15:0] n, input int unsigned aw);
    return {1'b0, n} > (17'd1 << aw);
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Instruction RAM write port driven by the boot loader.
interface uart_boot_loader_if #(parameter int MEM_AW = 10);
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       hclk_i,
  input  logic       hresetn_i,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        // A glitch shorter than half a bit is not a start bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          state_d = RX_IDLE;
          if (rx_s) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchronizer, edge history and receiver state.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a program image from UART into instruction RAM and then releases the CPU.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int         MEM_AW       = 10,
  parameter logic [7:0] MAGIC        = DEFAULT_MAGIC
) (
  input  logic                hclk_i,
  input  logic                hresetn_i,
  input  logic                uart_rxd_i,
  input  logic                boot_sel_i,
  uart_boot_loader_if.master  mem,
  output logic                cpu_resetn_o,
  output logic                boot_done_o,
  output logic                boot_err_o
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e AFTER_DATA = CSUM;
`else
  localparam boot_state_e AFTER_DATA = DONE;
`endif

  logic        rx_valid_s;
  logic [7:0]  rx_byte_s;
  logic        rx_ferr_s;

  boot_state_e       state_q, state_d;
  logic              first_q, first_d;
  logic              bypass_q, bypass_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              cpu_q, cpu_d;
  logic              err_q, err_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .hclk_i       (hclk_i),
    .hresetn_i    (hresetn_i),
    .rxd_i        (uart_rxd_i),
    .byte_valid_o (rx_valid_s),
    .byte_o       (rx_byte_s),
    .frame_err_o  (rx_ferr_s)
  );

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    bypass_d   = bypass_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    if (first_q) begin
      first_d = 1'b0;
      if (boot_sel_i) begin
        state_d  = DONE;
        bypass_d = 1'b1;
      end else begin
        state_d = WAIT_MAGIC;
      end
    end else begin
      case (state_q)
        WAIT_MAGIC: begin
          if (rx_valid_s && (rx_byte_s == MAGIC)) begin
            state_d    = LEN_LO;
            err_d      = 1'b0;
            csum_d     = 8'd0;
            word_cnt_d = 16'd0;
            byte_idx_d = 2'd0;
          end else begin
            state_d = WAIT_MAGIC;
          end
        end
        LEN_LO: begin
          if (rx_ferr_s) begin
            state_d = ERR;
          end else if (rx_valid_s) begin
            len_d   = {8'd0, rx_byte_s};
            state_d = LEN_HI;
          end else begin
            state_d = LEN_LO;
          end
        end
        LEN_HI: begin
          if (rx_ferr_s) begin
            state_d = ERR;
          end else if (rx_valid_s) begin
            len_d = {rx_byte_s, len_q[7:0]};
            if (len_oversize(len_d, unsigned'(MEM_AW))) begin
              state_d = ERR;
            end else if (len_d == 16'd0) begin
              state_d = AFTER_DATA;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = LEN_HI;
          end
        end
        DATA: begin
          if (rx_ferr_s) begin
            state_d = ERR;
          end else if (rx_valid_s) begin
            csum_d     = csum_q + rx_byte_s;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we_d   = 1'b1;
              addr_d     = word_cnt_q[MEM_AW-1:0];
              wdata_d    = {rx_byte_s, word_q};
              word_cnt_d = word_cnt_q + 16'd1;
              state_d    = (word_cnt_d == len_q) ? AFTER_DATA : DATA;
            end else begin
              // Bytes arrive LSB first, so shift down from the top.
              word_d = {rx_byte_s, word_q[23:8]};
            end
          end else begin
            state_d = DATA;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CSUM: begin
          if (rx_ferr_s) begin
            state_d = ERR;
          end else if (rx_valid_s) begin
            state_d = (rx_byte_s == csum_q) ? DONE : ERR;
          end else begin
            state_d = CSUM;
          end
        end
`endif
        DONE:    state_d = DONE;
        ERR:     state_d = WAIT_MAGIC;
        default: state_d = WAIT_MAGIC;
      endcase
    end
    if (state_d == ERR) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // A bypassed boot releases the core together with boot_done; a loaded image one cycle later.
  assign done_d = (state_q == DONE);
  assign cpu_d  = (state_q == DONE) && (done_q || bypass_q);

  // Frame FSM, counters and registered outputs.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q    <= WAIT_MAGIC;
      first_q    <= 1'b1;
      bypass_q   <= 1'b0;
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      csum_q     <= 8'd0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      cpu_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      bypass_q   <= bypass_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      cpu_q      <= cpu_d;
      err_q      <= err_d;
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign cpu_resetn_o  = cpu_q;
  assign boot_done_o   = done_q;
  assign boot_err_o    = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: random frames against an image/write-list model.
module tb_uart_boot_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic hclk     = 1'b0;
  logic rst_n    = 1'b0;
  logic rxd      = 1'b1;
  logic boot_sel = 1'b0;
  logic cpu_resetn, boot_done, boot_err;

  uart_boot_loader_if #(.MEM_AW(AW)) mif ();

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .MEM_AW(AW), .MAGIC(8'hA5)) dut (
    .hclk_i       (hclk),
    .hresetn_i    (rst_n),
    .uart_rxd_i   (rxd),
    .boot_sel_i   (boot_sel),
    .mem          (mif.master),
    .cpu_resetn_o (cpu_resetn),
    .boot_done_o  (boot_done),
    .boot_err_o   (boot_err)
  );

  always #5 hclk = ~hclk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [35:0] obs_q[$];
  logic [35:0] exp_q[$];
  logic [7:0]  fr_q[$];
  logic [31:0] wd_q[$];

  // Every RAM write the DUT makes, in order.
  always @(negedge hclk) begin
    if (mif.mem_we === 1'b1) obs_q.push_back({mif.mem_addr, mif.mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge hclk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge hclk);
    end
    rxd = stop;
    repeat (CPB) @(negedge hclk);
    rxd = 1'b1;
    repeat (stop ? 2 : 3 * CPB) @(negedge hclk);
  endtask

  // Sends fr_q; the byte at bad_idx gets a 0 stop bit and ends the transmission.
  task automatic send_frame(input int bad_idx);
    for (int i = 0; i < fr_q.size(); i++) begin
      send_byte(fr_q[i], i != bad_idx);
      if (i == bad_idx) break;
    end
    repeat (4 * CPB) @(negedge hclk);
  endtask

  task automatic build_frame(input int n, input int csum_delta);
    logic [7:0] sum;
    logic [15:0] n16;
    logic [31:0] w;
    n16 = 16'(n);
    sum = 8'd0;
    fr_q.delete();
    wd_q.delete();
    fr_q.push_back(8'hA5);
    fr_q.push_back(n16[7:0]);
    fr_q.push_back(n16[15:8]);
    for (int i = 0; i < n && i < 64; i++) begin
      w = $urandom;
      wd_q.push_back(w);
      for (int b = 0; b < 4; b++) begin
        fr_q.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    fr_q.push_back(sum + 8'(csum_delta));
`else
    if (csum_delta != 0) sum = 8'd0;
`endif
  endtask

  task automatic expect_words(input int cnt);
    logic [AW-1:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = AW'(i);
      exp_q.push_back({a, wd_q[i]});
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic done, input logic err);
    check({tag, "_done"}, boot_done, done);
    check({tag, "_err"},  boot_err,  err);
    check({tag, "_cpu"},  cpu_resetn, done);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_zero"},
          {mif.mem_we, mif.mem_addr, mif.mem_wdata, cpu_resetn, boot_done, boot_err},
          64'd0);
  endtask

  task automatic do_reset(input logic sel);
    @(negedge hclk);
    rst_n    = 1'b0;
    boot_sel = sel;
    rxd      = 1'b1;
    repeat (2) @(negedge hclk);
    check_zero("reset");
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic watch_done();
    for (int i = 0; i < 5000 && boot_done !== 1'b1; i++) @(negedge hclk);
    check("t1_done_seen", boot_done, 1'b1);
    check("t1_cpu_before", cpu_resetn, 1'b0);
    @(negedge hclk);
    check("t1_cpu_after", cpu_resetn, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    logic [7:0] sum;

    // 1: fixed two-word image
    do_reset(1'b0);
    fr_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wd_q = '{32'h12345678, 32'hDEADBEEF};
    sum = 8'd0;
    for (int i = 3; i < 11; i++) sum = sum + fr_q[i];
`ifdef BOOT_CHECKSUM_EN
    fr_q.push_back(sum);
`endif
    expect_words(2);
    fork
      send_frame(-1);
      watch_done();
    join
    compare_writes("t1");
    check_status("t1", 1'b1, 1'b0);
    build_frame(1, 0);
    send_frame(-1);
    compare_writes("t1_sticky");
    check_status("t1_sticky", 1'b1, 1'b0);

    // 2: bypass
    do_reset(1'b1);
    @(negedge hclk);
    check("t2_edge1", {boot_done, cpu_resetn}, 2'b00);
    boot_sel = 1'b0;
    @(negedge hclk);
    check("t2_edge2", {boot_done, cpu_resetn}, 2'b11);
    repeat (20) @(negedge hclk);
    compare_writes("t2");

    // 3: junk before MAGIC, framing error while hunting, empty image
    do_reset(1'b0);
    send_byte(8'h33, 1'b0);
    check("t3_hunt_ferr", boot_err, 1'b0);
    fr_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    fr_q.push_back(8'h00);
`endif
    send_frame(-1);
    check_status("t3", 1'b1, 1'b0);
    compare_writes("t3");

    // 4: oversize by one, then a full-size image
    do_reset(1'b0);
    fr_q = '{8'hA5, 8'h11, 8'h00};
    send_frame(-1);
    check_status("t4_over", 1'b0, 1'b1);
    compare_writes("t4_over");
    build_frame(16, 0);
    expect_words(16);
    send_frame(-1);
    compare_writes("t4_full");
    check_status("t4_full", 1'b1, 1'b0);

    // 5: framing errors, random oversize, bad checksum, recovery
    do_reset(1'b0);
    build_frame(3, 0);
    send_frame(1);
    check_status("t5_len_ferr", 1'b0, 1'b1);
    compare_writes("t5_len_ferr");
    repeat (4) begin
      n = $urandom_range(1, 16);
      build_frame(n, 0);
      k = $urandom_range(0, 4 * n - 1);
      expect_words(k / 4);
      send_frame(3 + k);
      compare_writes("t5_ferr");
      check_status("t5_ferr", 1'b0, 1'b1);
    end
    n = $urandom_range(17, 65535);
    build_frame(n, 0);
    send_frame(2);
    send_frame(-1);
    n = 0;
    check_status("t5_over", 1'b0, 1'b1);
    compare_writes("t5_over");
`ifdef BOOT_CHECKSUM_EN
    n = $urandom_range(1, 16);
    build_frame(n, 1);
    expect_words(n);
    send_frame(-1);
    compare_writes("t5_badsum");
    check_status("t5_badsum", 1'b0, 1'b1);
`endif
    n = $urandom_range(1, 16);
    build_frame(n, 0);
    expect_words(n);
    send_frame(-1);
    compare_writes("t5_retry");
    check_status("t5_retry", 1'b1, 1'b0);

    // 6: reset in the middle of the data phase
    do_reset(1'b0);
    build_frame(8, 0);
    for (int i = 0; i < 13; i++) send_byte(fr_q[i], 1'b1);
    repeat (4) @(negedge hclk);
    expect_words(2);
    compare_writes("t6_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    repeat (2) @(negedge hclk);
    rst_n = 1'b1;
    for (int i = 13; i < fr_q.size(); i++)
      send_byte((fr_q[i] == 8'hA5) ? 8'h5A : fr_q[i], 1'b1);
    repeat (4 * CPB) @(negedge hclk);
    compare_writes("t6_tail");
    check_status("t6_tail", 1'b0, 1'b0);
    n = $urandom_range(1, 16);
    build_frame(n, 0);
    expect_words(n);
    send_frame(-1);
    compare_writes("t6_fresh");
    check_status("t6_fresh", 1'b1, 1'b0);

    // random valid images, each from reset
    repeat (3) begin
      do_reset(1'b0);
      n = $urandom_range(0, 16);
      build_frame(n, 0);
      expect_words(n);
      send_frame(-1);
      compare_writes("rand");
      check_status("rand", 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
